// File: rtl/execute_stage.sv
// Y86-64 execute stage: computes valE, the branch/move condition and the
// condition codes, then registers the results for the memory stage.
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  output logic        out_valid,
  output logic [3:0]  icode_out,
  output logic [63:0] valE,
  output logic [63:0] valA_out,
  output logic [63:0] valP_out,
  output logic        cnd,
  output logic [2:0]  cc,
  output logic [1:0]  stat
);

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_INS = 2'b10;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic signed [63:0] WORD_8 = 64'sd8;

  function automatic logic signed [63:0] alu_op(input logic [3:0] fn,
                                                input logic signed [63:0] a,
                                                input logic signed [63:0] b);
    case (fn[1:0])
      2'd0:    alu_op = b + a;
      2'd1:    alu_op = b - a;
      2'd2:    alu_op = b & a;
      default: alu_op = b ^ a;
    endcase
  endfunction

  // Returns {ZF, SF, OF}; overflow only exists for add and sub.
  function automatic logic [2:0] alu_flags(input logic [3:0] fn,
                                           input logic signed [63:0] a,
                                           input logic signed [63:0] b,
                                           input logic signed [63:0] t);
    logic of;
    case (fn[1:0])
      2'd0:    of = (a[63] == b[63]) && (t[63] != b[63]);
      2'd1:    of = (a[63] != b[63]) && (t[63] != b[63]);
      default: of = 1'b0;
    endcase
    alu_flags = {(t == 64'sd0), t[63], of};
  endfunction

  function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] flags);
    logic zf, lt;
    zf = flags[2];
    lt = flags[1] ^ flags[0];
    case (fn)
      4'd0:    cond_eval = 1'b1;
      4'd1:    cond_eval = lt | zf;
      4'd2:    cond_eval = lt;
      4'd3:    cond_eval = zf;
      4'd4:    cond_eval = ~zf;
      4'd5:    cond_eval = ~lt;
      4'd6:    cond_eval = ~lt & ~zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  logic                halted;
  logic                accept_p0;
  logic                bad_p0;
  logic signed [63:0]  a_p0, b_p0, c_p0;
  logic signed [63:0]  alu_p0;
  logic signed [63:0]  vale_p0;
  logic [2:0]          flags_p0;
  logic                cnd_p0;

  assign accept_p0 = in_valid && !halted;
  assign a_p0      = valA;
  assign b_p0      = valB;
  assign c_p0      = valC;

  assign bad_p0 = (icode > I_POPQ) ||
                  ((icode == I_OPQ) && (ifun > 4'd3)) ||
                  (((icode == I_RRMOVQ) || (icode == I_JXX)) && (ifun > 4'd6));

  assign alu_p0   = alu_op(ifun, a_p0, b_p0);
  assign flags_p0 = alu_flags(ifun, a_p0, b_p0, alu_p0);

  always_comb begin
    vale_p0 = 64'sd0;
    cnd_p0  = 1'b0;
    if (!bad_p0) begin
      case (icode)
        I_RRMOVQ: begin
          vale_p0 = a_p0;
          cnd_p0  = cond_eval(ifun, cc);
        end
        I_IRMOVQ:          vale_p0 = c_p0;
        I_RMMOVQ, I_MRMOVQ: vale_p0 = b_p0 + c_p0;
        I_OPQ:             vale_p0 = alu_p0;
        I_CALL, I_PUSHQ:   vale_p0 = b_p0 - WORD_8;
        I_RET, I_POPQ:     vale_p0 = b_p0 + WORD_8;
        I_JXX:             cnd_p0  = cond_eval(ifun, cc);
        default:           vale_p0 = 64'sd0;
      endcase
    end
  end

  // ---- p0 -> output register boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      icode_out <= 4'h0;
      valE      <= 64'h0;
      valA_out  <= 64'h0;
      valP_out  <= 64'h0;
      cnd       <= 1'b0;
      cc        <= 3'b100;
      stat      <= STAT_AOK;
      halted    <= 1'b0;
    end else begin
      out_valid <= accept_p0;
      if (accept_p0) begin
        icode_out <= icode;
        valE      <= vale_p0;
        valA_out  <= valA;
        valP_out  <= valP;
        cnd       <= cnd_p0;
        if (!bad_p0 && (icode == I_OPQ))
          cc <= flags_p0;
        if (bad_p0) begin
          stat   <= STAT_INS;
          halted <= 1'b1;
        end else if (icode == I_HALT) begin
          stat   <= STAT_HLT;
          halted <= 1'b1;
        end else begin
          stat   <= STAT_AOK;
        end
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: spec-level reference model checked every cycle,
// plus hand-computed expectations for the directed vectors.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  icode, ifun;
  logic [63:0] valA, valB, valC, valP;
  logic        out_valid;
  logic [3:0]  icode_out;
  logic [63:0] valE, valA_out, valP_out;
  logic        cnd;
  logic [2:0]  cc;
  logic [1:0]  stat;

  int checks = 0;
  int errors = 0;

  execute_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .icode(icode), .ifun(ifun),
    .valA(valA), .valB(valB), .valC(valC), .valP(valP),
    .out_valid(out_valid), .icode_out(icode_out), .valE(valE),
    .valA_out(valA_out), .valP_out(valP_out), .cnd(cnd), .cc(cc), .stat(stat)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what the registered outputs must hold after each edge.
  logic        m_halted, m_ov, m_cnd;
  logic [3:0]  m_icode;
  logic [63:0] m_valE, m_valA, m_valP;
  logic [2:0]  m_cc;
  logic [1:0]  m_stat;

  always @(posedge clk or posedge rst) begin
    logic [64:0] wide;
    logic [63:0] t;
    logic        zf, sf, of, bad;
    if (rst) begin
      m_halted = 0; m_ov = 0; m_cnd = 0; m_icode = 0;
      m_valE = 0; m_valA = 0; m_valP = 0; m_cc = 3'b100; m_stat = 2'd0;
    end else begin
      m_ov = 0;
      if (in_valid && !m_halted) begin
        m_ov    = 1;
        m_icode = icode;
        m_valA  = valA;
        m_valP  = valP;
        bad = (icode >= 4'hC) || (icode == 4'h6 && ifun >= 4'd4) ||
              ((icode == 4'h2 || icode == 4'h7) && ifun >= 4'd7);
        m_cnd  = 0;
        m_valE = 0;
        if (bad) begin
          m_stat = 2'd2; m_halted = 1;
        end else begin
          m_stat = (icode == 4'h0) ? 2'd1 : 2'd0;
          if (icode == 4'h0) m_halted = 1;
          if (icode == 4'h2 || icode == 4'h7) begin
            zf = m_cc[2]; sf = m_cc[1]; of = m_cc[0];
            case (ifun)
              0: m_cnd = 1;
              1: m_cnd = (sf != of) || zf;
              2: m_cnd = (sf != of);
              3: m_cnd = zf;
              4: m_cnd = !zf;
              5: m_cnd = (sf == of);
              default: m_cnd = (sf == of) && !zf;
            endcase
          end
          case (icode)
            4'h2: m_valE = valA;
            4'h3: m_valE = valC;
            4'h4, 4'h5: m_valE = valB + valC;
            4'h8, 4'hA: m_valE = valB - 64'd8;
            4'h9, 4'hB: m_valE = valB + 64'd8;
            4'h6: begin
              of = 0;
              case (ifun)
                0: begin wide = {valB[63], valB} + {valA[63], valA}; t = wide[63:0]; of = wide[64] != wide[63]; end
                1: begin wide = {valB[63], valB} - {valA[63], valA}; t = wide[63:0]; of = wide[64] != wide[63]; end
                2: t = valB & valA;
                default: t = valB ^ valA;
              endcase
              m_valE = t;
              m_cc = {t == 64'd0, t[63], of};
            end
            default: m_valE = 0;
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      cmp("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
      cmp("icode_out", {60'd0, icode_out}, {60'd0, m_icode});
      cmp("valE", valE, m_valE);
      cmp("valA_out", valA_out, m_valA);
      cmp("valP_out", valP_out, m_valP);
      cmp("cnd", {63'd0, cnd}, {63'd0, m_cnd});
      cmp("cc", {61'd0, cc}, {61'd0, m_cc});
      cmp("stat", {62'd0, stat}, {62'd0, m_stat});
    end
  end

  task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] c, input logic [63:0] p);
    in_valid = 1; icode = ic; ifun = fn; valA = a; valB = b; valC = c; valP = p;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1; #1;
    cmp("rst_cc", {61'd0, cc}, 64'd4);
    cmp("rst_stat", {62'd0, stat}, 64'd0);
    cmp("rst_out_valid", {63'd0, out_valid}, 64'd0);
    cmp("rst_valE", valE, 64'd0);
    @(posedge clk); #1;
    rst = 0; in_valid = 0;
  endtask

  initial begin
    rst = 1; in_valid = 0; icode = 0; ifun = 0;
    valA = 0; valB = 0; valC = 0; valP = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    cmp("init_cc", {61'd0, cc}, 64'd4);
    cmp("init_stat", {62'd0, stat}, 64'd0);

    // OPq sub equal operands, then xor
    send(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 64'h10);
    cmp("sub_valE", valE, 64'd0);
    cmp("sub_cc", {61'd0, cc}, 64'd4);
    send(4'h6, 4'h3, 64'd3, 64'd5, 64'd0, 64'h12);
    cmp("xor_valE", valE, 64'd6);
    cmp("xor_cc", {61'd0, cc}, 64'd0);
    idle(1);
    cmp("idle_out_valid", {63'd0, out_valid}, 64'd0);
    cmp("idle_valE_hold", valE, 64'd6);

    // signed overflow, then back-to-back conditionals (ZF=0 SF=1 OF=1)
    send(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'h14);
    cmp("add_valE", valE, 64'h8000_0000_0000_0000);
    cmp("add_cc", {61'd0, cc}, 64'd3);
    send(4'h7, 4'h2, 64'd0, 64'd0, 64'h99, 64'h1E);
    cmp("jl_cnd", {63'd0, cnd}, 64'd0);
    send(4'h7, 4'h5, 64'd0, 64'd0, 64'h99, 64'h27);
    cmp("jge_cnd", {63'd0, cnd}, 64'd1);
    send(4'h2, 4'h6, 64'h1234, 64'd0, 64'd0, 64'h29);
    cmp("cmovg_cnd", {63'd0, cnd}, 64'd1);
    cmp("cmovg_valE", valE, 64'h1234);
    send(4'h3, 4'h0, 64'd0, 64'd0, 64'hABCD, 64'h33);
    cmp("irmovq_valE", valE, 64'hABCD);

    // address arithmetic leaves cc alone
    send(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 64'h35);
    cmp("push_valE", valE, 64'hF8);
    send(4'hB, 4'h0, 64'd0, 64'hF8, 64'd0, 64'h37);
    cmp("pop_valE", valE, 64'h100);
    send(4'h5, 4'h0, 64'd0, 64'd2, 64'd5, 64'h41);
    cmp("mrmov_valE", valE, 64'd7);
    send(4'h8, 4'h0, 64'd0, 64'h40, 64'd0, 64'h1C);
    cmp("call_valE", valE, 64'h38);
    cmp("call_valP", valP_out, 64'h1C);
    cmp("addr_cc", {61'd0, cc}, 64'd3);

    // halt, then further instructions are ignored
    send(4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 64'h50);
    cmp("halt_out_valid", {63'd0, out_valid}, 64'd1);
    cmp("halt_stat", {62'd0, stat}, 64'd1);
    in_valid = 1; icode = 4'h6; ifun = 4'h0; valA = 64'd1; valB = 64'd1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmp("halted_out_valid", {63'd0, out_valid}, 64'd0);
    cmp("halted_cc", {61'd0, cc}, 64'd3);
    cmp("halted_stat", {62'd0, stat}, 64'd1);
    in_valid = 0;
    do_reset();
    send(4'h6, 4'h0, 64'd2, 64'd3, 64'd0, 64'h60);
    cmp("post_rst_valid", {63'd0, out_valid}, 64'd1);
    cmp("post_rst_valE", valE, 64'd5);
    cmp("post_rst_stat", {62'd0, stat}, 64'd0);

    // reset asserted mid-cycle with an instruction pending
    in_valid = 1; icode = 4'h6; ifun = 4'h0; valA = 64'd9; valB = 64'd9;
    #3;
    do_reset();

    // invalid icode
    send(4'hC, 4'h0, 64'd4, 64'd4, 64'd4, 64'h70);
    cmp("insC_stat", {62'd0, stat}, 64'd2);
    cmp("insC_valE", valE, 64'd0);
    cmp("insC_cc", {61'd0, cc}, 64'd4);
    send(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 64'h72);
    cmp("insC_halted", {63'd0, out_valid}, 64'd0);
    do_reset();

    // OPq with bad function code
    send(4'h6, 4'h1, 64'd1, 64'd1, 64'd0, 64'h80);
    send(4'h6, 4'h7, 64'd3, 64'd5, 64'd0, 64'h82);
    cmp("insOP_stat", {62'd0, stat}, 64'd2);
    cmp("insOP_valE", valE, 64'd0);
    cmp("insOP_cc", {61'd0, cc}, 64'd4);
    send(4'h7, 4'h0, 64'd0, 64'd0, 64'd0, 64'h84);
    cmp("insOP_halted", {63'd0, out_valid}, 64'd0);
    do_reset();

    // jXX with bad condition code
    send(4'h7, 4'h7, 64'd0, 64'd0, 64'h10, 64'h90);
    cmp("insJ_stat", {62'd0, stat}, 64'd2);
    cmp("insJ_cnd", {63'd0, cnd}, 64'd0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
